// File: rtl/lane_input_conditioner_if.sv
// Key/move signal bundle between the push-button input conditioner and the player FSM.
// master: the conditioner side (samples keys, drives move requests and busy).
// slave:  the consumer side (drives raw keys, observes move requests).
interface lane_input_conditioner_if;
    logic KEY_left;
    logic KEY_right;
    logic move_left;
    logic move_right;
    logic busy;

    modport master (
        input  KEY_left,
        input  KEY_right,
        output move_left,
        output move_right,
        output busy
    );

    modport slave (
        output KEY_left,
        output KEY_right,
        input  move_left,
        input  move_right,
        input  busy
    );
endinterface

// File: rtl/lane_input_conditioner.sv
// Lane input conditioner: turns two raw push-buttons into clean, long-held
// move_left / move_right requests with an enforced gap and auto-repeat.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no request pending, waiting for a debounced press edge
// ASSERT | selected move output held high for ASSERT_CYCLES
// GAP    | both outputs forced low for GAP_CYCLES
// HOLD   | key still held: wait for release, opposite press or repeat
module lane_input_conditioner #(
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ASSERT_CYCLES   = 8192,
    parameter int GAP_CYCLES      = 16,
    parameter int REPEAT_CYCLES   = 15000000,
    parameter int CNT_W           = 24
) (
    input  logic                      Clock,
    input  logic                      Reset,
    lane_input_conditioner_if.master  lane
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] AS_LAST   = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LIMIT = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic             ACT_LOW   = (KEY_ACTIVE_LOW != 0);

    // Index 0 is the left key, index 1 the right key throughout.
    logic [1:0]       raw_pressed;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [1:0]       deb_q;
    logic [1:0]       press;
    logic [CNT_W-1:0] db_cnt [2];

    state_t           state;
    state_t           state_nxt;
    logic             dir;        // 0 = left, 1 = right
    logic             dir_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic             move_l_q;
    logic             move_r_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Normalise to "1 = pressed" before the synchroniser so reset value means released.
    assign raw_pressed = {lane.KEY_right, lane.KEY_left} ^ {2{ACT_LOW}};

    // Two-flop synchroniser for the asynchronous key inputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_pressed;
            sync2 <= sync1;
        end
    end

    // Debounce: accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            deb       <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == deb[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] >= DB_LAST) begin
                    deb[k]    <= ~deb[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= sat_inc(db_cnt[k]);
                end
            end
        end
    end

    // Registered rising-edge detect on the debounced levels.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            deb_q <= '0;
            press <= '0;
        end else begin
            deb_q <= deb;
            press <= deb & ~deb_q;
        end
    end

    // FSM state, direction and timer registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            dir   <= 1'b0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
            timer <= timer_nxt;
        end
    end

    // Next-state logic; press edges seen in ASSERT or GAP are simply ignored.
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        timer_nxt = timer;
        unique case (state)
            IDLE: begin
                if (press[0]) begin
                    state_nxt = ASSERT;
                    dir_nxt   = 1'b0;
                    timer_nxt = '0;
                end else if (press[1]) begin
                    state_nxt = ASSERT;
                    dir_nxt   = 1'b1;
                    timer_nxt = '0;
                end
            end
            ASSERT: begin
                if (timer >= AS_LAST) begin
                    state_nxt = GAP;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = sat_inc(timer);
                end
            end
            GAP: begin
                if (timer >= GAP_LAST) begin
                    state_nxt = HOLD;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = sat_inc(timer);
                end
            end
            HOLD: begin
                if (!deb[dir]) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else if (press[~dir]) begin
                    state_nxt = ASSERT;
                    dir_nxt   = ~dir;
                    timer_nxt = '0;
                end else if (timer >= REP_LIMIT) begin
                    state_nxt = ASSERT;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = sat_inc(timer);
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // Registered move outputs; one-hot by construction since dir selects exactly one.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            move_l_q <= 1'b0;
            move_r_q <= 1'b0;
        end else begin
            move_l_q <= (state == ASSERT) && !dir;
            move_r_q <= (state == ASSERT) && dir;
        end
    end

    assign lane.move_left  = move_l_q;
    assign lane.move_right = move_r_q;
    assign lane.busy       = (state != IDLE);

endmodule

// File: tb/tb_lane_input_conditioner.sv
// Scoreboard bench for lane_input_conditioner with small timing parameters.
module tb_lane_input_conditioner;

    localparam int DB   = 4;
    localparam int AC   = 8;
    localparam int GC   = 2;
    localparam int RC   = 20;
    localparam int MAXN = 128;
    localparam int TAIL = 64;
    localparam int MAXH = MAXN + TAIL;

    typedef struct {
        bit dir;      // 0 = left, 1 = right
        int start;    // edge index after which the pulse is first seen high
    } exp_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    lane_input_conditioner_if lane_if ();

    lane_input_conditioner #(
        .KEY_ACTIVE_LOW  (1),
        .DEBOUNCE_CYCLES (DB),
        .ASSERT_CYCLES   (AC),
        .GAP_CYCLES      (GC),
        .REPEAT_CYCLES   (RC),
        .CNT_W           (8)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .lane  (lane_if)
    );

    always #5 Clock = ~Clock;

    int   errors = 0;
    int   checks = 0;
    int   e_idx  = -1;
    exp_t exp_q[$];

    bit stim_l [0:MAXN-1];
    bit stim_r [0:MAXN-1];
    bit mdl    [0:MAXH];
    bit mdr    [0:MAXH];

    // monitor-owned observations
    int pulses_seen = 0;
    int last_rise   = 0;
    int last_dir    = 0;
    int last_len    = 0;
    int last_gap    = 0;
    bit abort_pulse = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, expv, e_idx);
        end
    endtask

    initial forever begin
        @(posedge Clock);
        e_idx++;
    end

    // ---------------- reference model ----------------
    function automatic bit deb_at(input bit k, input int j);
        if (j < 0) return 1'b0;
        return k ? mdr[j] : mdl[j];
    endfunction

    // FSM acts on a press at edge e when the debounced level rose at edge e-2.
    function automatic bit press_at(input bit k, input int e);
        return deb_at(k, e - 2) && !deb_at(k, e - 3);
    endfunction

    task automatic plan(input int base, input int n);
        int  h = n + TAIL;
        int  e;
        int  tmr;
        bit  dir;
        bit  active;
        for (int k = 0; k < 2; k++) begin
            bit lvl = 0;
            int run = 0;
            for (int j = 0; j <= h; j++) begin
                // level reaching the debouncer at edge j was applied two edges earlier
                bit s = (j >= 2 && j - 2 < n) ? (k == 0 ? stim_l[j-2] : stim_r[j-2]) : 1'b0;
                run = (s != lvl) ? run + 1 : 0;
                if (run == DB) begin
                    lvl = s;
                    run = 0;
                end
                if (k == 0) mdl[j] = lvl; else mdr[j] = lvl;
            end
        end
        e = 0; tmr = 0; dir = 0; active = 0;
        while (e <= h) begin
            if (!active) begin
                if (press_at(0, e)) begin
                    dir = 0; active = 1;
                end else if (press_at(1, e)) begin
                    dir = 1; active = 1;
                end
                if (active) begin
                    exp_q.push_back('{dir: dir, start: base + e + 1});
                    e   = e + AC + GC + 1;
                    tmr = 0;
                end else begin
                    e++;
                end
            end else begin
                if (!deb_at(dir, e - 1)) begin
                    active = 0;
                    e++;
                end else if (press_at(!dir, e)) begin
                    dir = !dir;
                    exp_q.push_back('{dir: dir, start: base + e + 1});
                    e   = e + AC + GC + 1;
                    tmr = 0;
                end else if (tmr == RC) begin
                    exp_q.push_back('{dir: dir, start: base + e + 1});
                    e   = e + AC + GC + 1;
                    tmr = 0;
                end else begin
                    tmr++;
                    e++;
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input int n, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            lane_if.KEY_left  = (i < n) ? ~stim_l[i] : 1'b1;
            lane_if.KEY_right = (i < n) ? ~stim_r[i] : 1'b1;
            @(negedge Clock);
        end
    endtask

    task automatic run_scenario(input string name, input int n, output int base, output int p0);
        @(negedge Clock);
        base = e_idx + 1;
        p0   = pulses_seen;
        plan(base, n);
        drive(n, n + TAIL + AC + 4);
        chk({name, "_q_empty"}, exp_q.size(), 0);
        chk({name, "_busy_end"}, int'(lane_if.busy), 0);
        chk({name, "_moves_end"}, int'(lane_if.move_left | lane_if.move_right), 0);
    endtask

    task automatic set_stim(input int n, input int l0, input int l1, input int r0, input int r1);
        for (int i = 0; i < MAXN; i++) begin
            stim_l[i] = (i >= l0 && i < l1);
            stim_r[i] = (i >= r0 && i < r1);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit   prev_any = 0;
        bit   excl_bad = 0;
        bit   have_fall = 0;
        int   fall_e = 0;
        int   run = 0;
        exp_t x;
        forever begin
            @(negedge Clock);
            if (lane_if.move_left && lane_if.move_right) excl_bad = 1;
            if ((lane_if.move_left | lane_if.move_right) && !prev_any) begin
                pulses_seen++;
                last_rise = e_idx;
                last_dir  = int'(lane_if.move_right);
                run       = 0;
                excl_bad  = lane_if.move_left && lane_if.move_right;
                if (have_fall) begin
                    last_gap = e_idx - fall_e;
                    chk("gap_min", int'(last_gap >= GC), 1);
                end
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", e_idx, -1);
                end else begin
                    x = exp_q.pop_front();
                    chk("pulse_start", e_idx, x.start);
                    chk("pulse_dir", int'(lane_if.move_right), int'(x.dir));
                end
            end
            if (lane_if.move_left | lane_if.move_right) run++;
            if (!(lane_if.move_left | lane_if.move_right) && prev_any) begin
                fall_e    = e_idx;
                have_fall = 1;
                last_len  = run;
                if (!abort_pulse) begin
                    chk("pulse_len", run, AC);
                    chk("excl", int'(excl_bad), 0);
                end
            end
            prev_any = lane_if.move_left | lane_if.move_right;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int p0;
        int wait_n;
        lane_if.KEY_left  = 1'b1;
        lane_if.KEY_right = 1'b1;
        repeat (3) @(negedge Clock);
        chk("rst_move_left", int'(lane_if.move_left), 0);
        chk("rst_move_right", int'(lane_if.move_right), 0);
        chk("rst_busy", int'(lane_if.busy), 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);

        // short glitch never propagates
        set_stim(3, 0, 3, 0, 0);
        run_scenario("glitch", 3, base, p0);
        chk("glitch_pulses", pulses_seen - p0, 0);

        // single press: high on edges 8..15 relative to first sample
        set_stim(12, 0, 12, 0, 0);
        run_scenario("single", 12, base, p0);
        chk("single_pulses", pulses_seen - p0, 1);
        chk("single_latency", last_rise - base, DB + 4);
        chk("single_len", last_len, AC);
        chk("single_dir", last_dir, 0);

        // simultaneous press: left wins
        set_stim(12, 0, 12, 0, 12);
        run_scenario("simul", 12, base, p0);
        chk("simul_pulses", pulses_seen - p0, 1);
        chk("simul_dir", last_dir, 0);

        // held right: auto-repeat 2+20+1 cycles after each pulse ends
        set_stim(60, 0, 0, 0, 60);
        run_scenario("repeat", 60, base, p0);
        chk("repeat_pulses", pulses_seen - p0, 2);
        chk("repeat_gap", last_gap, GC + RC + 1);

        // right during left ASSERT dropped, right again in HOLD flips
        for (int i = 0; i < MAXN; i++) begin
            stim_l[i] = (i < 50);
            stim_r[i] = (i >= 10 && i < 15) || (i >= 25 && i < 50);
        end
        run_scenario("flip", 50, base, p0);
        chk("flip_pulses", pulses_seen - p0, 2);
        chk("flip_dir", last_dir, 1);
        chk("flip_start", last_rise - base, 33);

        // reset in the middle of a move_left assertion
        set_stim(12, 0, 12, 0, 0);
        @(negedge Clock);
        base = e_idx + 1;
        plan(base, 12);
        drive(12, 11);
        chk("pre_rst_move_left", int'(lane_if.move_left), 1);
        lane_if.KEY_left = 1'b1;
        abort_pulse = 1;
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_move_left", int'(lane_if.move_left), 0);
        chk("async_rst_busy", int'(lane_if.busy), 0);
        chk("rst_q_empty", exp_q.size(), 0);
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        abort_pulse = 0;
        p0 = pulses_seen;
        wait_n = 0;
        while (wait_n < 40) begin
            @(negedge Clock);
            wait_n++;
        end
        chk("post_rst_quiet", pulses_seen - p0, 0);
        set_stim(12, 0, 12, 0, 0);
        run_scenario("post_rst", 12, base, p0);
        chk("post_rst_pulses", pulses_seen - p0, 1);

        // randomized key activity with glitches
        for (int s = 0; s < 14; s++) begin
            int n = 100 + $urandom_range(0, 20);
            for (int k = 0; k < 2; k++) begin
                int  i = 0;
                bit  lvl = $urandom_range(0, 1);
                while (i < MAXN) begin
                    int len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
                    for (int j = 0; j < len && i < MAXN; j++) begin
                        if (k == 0) stim_l[i] = lvl && (i < n); else stim_r[i] = lvl && (i < n);
                        i++;
                    end
                    lvl = !lvl;
                end
            end
            run_scenario("rand", n, base, p0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
